// File: rtl/qtree_pkg.sv
// Shared types for the quadtree lookup pipeline and its update controller.
package qtree_pkg;

   localparam int unsigned QTREE_KEY_WIDTH      = 16;
   localparam int unsigned QTREE_RAM_ADDR_WIDTH = 8;
   localparam int unsigned QTREE_LEVEL_W        = 2;

   // One node key and the {l,m,r} triple held in each level RAM word.
   typedef logic [QTREE_KEY_WIDTH-1:0] level_data_t;

   typedef struct packed {
      level_data_t l;
      level_data_t m;
      level_data_t r;
   } level_ram_data_t;

   // Update sequencer states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      WRITE = 2'd2,
      GUARD = 2'd3
   } upd_state_t;

   // One registered level-RAM write: broadcast address/data plus target level.
   typedef struct packed {
      logic [QTREE_RAM_ADDR_WIDTH-1:0] addr;
      level_ram_data_t                 data;
      logic [QTREE_LEVEL_W-1:0]        level;
   } mm_wr_t;

   // True when a host-supplied level index addresses an existing level.
   function automatic logic level_in_range(input int unsigned level,
                                           input int unsigned level_cnt);
      return level < level_cnt;
   endfunction

endpackage

// File: rtl/qtree_inflight_cnt.sv
// Saturating up/down count of lookups currently inside the qtree levels.
module qtree_inflight_cnt #(
   parameter  int unsigned MAX   = 32,
   localparam int unsigned CNT_W = $clog2(MAX + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             at_max_o,
   output logic             underflow_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: simultaneous inc/dec cancel; clamp at both ends, flag a retire at zero.
   always_comb begin
      cnt_d       = cnt_q;
      underflow_o = 1'b0;
      if (inc_i && !dec_i) begin
         if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end else if (dec_i && !inc_i) begin
         if (cnt_q == '0) begin
            underflow_o = 1'b1;
         end else begin
            cnt_d = cnt_q - CNT_ONE;
         end
      end
   end

   // Count register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o    = cnt_q;
   assign at_max_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/qtree_update_ctrl.sv
// Quiesces lookup traffic, drains the qtree levels and streams host writes into the level RAMs.
module qtree_update_ctrl
   import qtree_pkg::*;
#(
   parameter  int unsigned LEVEL_CNT      = 4,
   parameter  int unsigned KEY_WIDTH      = QTREE_KEY_WIDTH,
   parameter  int unsigned RAM_ADDR_WIDTH = QTREE_RAM_ADDR_WIDTH,
   parameter  int unsigned INFLIGHT_MAX   = 32,
   localparam int unsigned LEVEL_W        = $clog2(LEVEL_CNT),
   localparam int unsigned CNT_W          = $clog2(INFLIGHT_MAX + 1)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      lkp_valid_i,
   output logic                      lkp_ready_o,
   output logic                      pipe_in_valid_o,
   input  logic                      pipe_out_valid_i,
   input  logic                      upd_valid_i,
   output logic                      upd_ready_o,
   input  logic [LEVEL_W-1:0]        upd_level_i,
   input  logic [RAM_ADDR_WIDTH-1:0] upd_addr_i,
   input  logic [KEY_WIDTH*3-1:0]    upd_data_i,
   input  logic                      upd_last_i,
   output logic [RAM_ADDR_WIDTH-1:0] mm_ram_addr_o,
   output logic [KEY_WIDTH*3-1:0]    mm_ram_data_o,
   output logic [LEVEL_CNT-1:0]      mm_ram_write_o,
   output logic                      busy_o,
   output logic [CNT_W-1:0]          inflight_o,
   output logic                      err_o
);

   localparam int unsigned RAM_DATA_W = $bits(level_ram_data_t);

   upd_state_t state_q, state_d;
   mm_wr_t     wr_q, wr_d;
   logic       wr_vld_q, wr_vld_d;
   logic       err_q, err_d;
   logic       upd_acc;
   logic       lvl_ok;
   logic       cnt_at_max;
   logic       cnt_underflow;

   qtree_inflight_cnt #(
      .MAX (INFLIGHT_MAX)
   ) u_inflight_cnt (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .inc_i       (pipe_in_valid_o),
      .dec_i       (pipe_out_valid_i),
      .cnt_o       (inflight_o),
      .at_max_o    (cnt_at_max),
      .underflow_o (cnt_underflow)
   );

   // Sequencer: lookups flow only in IDLE, and an offered update blocks them in the same cycle.
   always_comb begin
      state_d     = state_q;
      lkp_ready_o = 1'b0;
      upd_ready_o = 1'b0;
      case (state_q)
         IDLE: begin
            lkp_ready_o = ~upd_valid_i & ~cnt_at_max;
            if (upd_valid_i) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (inflight_o == '0) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            upd_ready_o = 1'b1;
            if (upd_valid_i && upd_last_i) begin
               state_d = GUARD;
            end
         end
         GUARD: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign pipe_in_valid_o = lkp_valid_i & lkp_ready_o;
   assign busy_o          = (state_q != IDLE);
   assign upd_acc         = upd_valid_i & upd_ready_o;
   assign lvl_ok          = level_in_range(32'(upd_level_i), LEVEL_CNT);

   // Write capture: each accepted beat is registered; bad levels raise the sticky error instead of a strobe.
   always_comb begin
      wr_d     = wr_q;
      wr_vld_d = 1'b0;
      err_d    = err_q | cnt_underflow;
      if (upd_acc) begin
         wr_d.addr  = QTREE_RAM_ADDR_WIDTH'(upd_addr_i);
         wr_d.data  = RAM_DATA_W'(upd_data_i);
         wr_d.level = QTREE_LEVEL_W'(upd_level_i);
         wr_vld_d   = lvl_ok;
         if (!lvl_ok) begin
            err_d = 1'b1;
         end
      end
   end

   // Strobe decode from the write register, one cycle after beat acceptance.
   always_comb begin
      mm_ram_write_o = '0;
      for (int unsigned n = 0; n < LEVEL_CNT; n++) begin
         mm_ram_write_o[n] = wr_vld_q && (32'(wr_q.level) == n);
      end
   end

   // State, write register and error flag; reset drops any strobe still pending.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         wr_q     <= '0;
         wr_vld_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_q     <= wr_d;
         wr_vld_q <= wr_vld_d;
         err_q    <= err_d;
      end
   end

   assign mm_ram_addr_o = RAM_ADDR_WIDTH'(wr_q.addr);
   assign mm_ram_data_o = (KEY_WIDTH * 3)'(wr_q.data);
   assign err_o         = err_q;

endmodule
